// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if: producer-side bus and line/status signals of uart_tx_fifo. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_tx_fifo_if #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 2
);
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              ovf_clr;
  logic              UART_TX;
  logic              tx_full;
  logic              tx_empty;
  logic [FIFO_AW:0]  tx_count;
  logic              tx_busy;
  logic              tx_ovf;

  modport master (
    output tx_en, tx_data, ovf_clr,
    input  UART_TX, tx_full, tx_empty, tx_count, tx_busy, tx_ovf
  );

  modport slave (
    input  tx_en, tx_data, ovf_clr,
    output UART_TX, tx_full, tx_empty, tx_count, tx_busy, tx_ovf
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo: UART transmitter with transmit FIFO, one bit per BRclk cycle. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 2
) (
  input  logic           BRclk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int               c_DEPTH_N   = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] c_DEPTH     = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [3:0]       c_LAST_BIT  = 4'(DATA_W - 1);
  localparam logic             c_LAST_STOP = (STOP_BITS == 2);
  localparam logic             c_HAS_PAR   = (PARITY != 0);
  localparam logic             c_ODD       = (PARITY == 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_START = 3'd1;
  localparam logic [2:0] c_DATA  = 3'd2;
  localparam logic [2:0] c_PAR   = 3'd3;
  localparam logic [2:0] c_STOP  = 3'd4;

  logic [DATA_W-1:0]  r_mem [0:c_DEPTH_N-1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [DATA_W-1:0]  r_shift;
  logic [3:0]         r_bit_cnt;
  logic               r_stop_cnt;
  logic               r_par;
  logic               r_line;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_line_next;
  logic               w_busy;
  logic [DATA_W-1:0]  w_head;
  logic               w_head_par;
  logic               w_last_bit;
  logic               w_last_stop;

  // Fullness is judged on the pre-edge count, so a same-edge pop never frees a slot.
  assign w_full      = (r_count == c_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.tx_en & ~w_full;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_par  = (^w_head) ^ c_ODD;
  assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
  assign w_last_stop = (r_stop_cnt == c_LAST_STOP);

  always_ff @(posedge BRclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.tx_data;
    end
  end

  always_ff @(posedge BRclk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (bus.tx_en && w_full) r_ovf <= 1'b1;
      else if (bus.ovf_clr)    r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge BRclk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (!w_empty) w_next_state = c_START;
      c_START: w_next_state = c_DATA;
      c_DATA:  if (w_last_bit) w_next_state = c_HAS_PAR ? c_PAR : c_STOP;
      c_PAR:   w_next_state = c_STOP;
      c_STOP:  if (w_last_stop) w_next_state = w_empty ? c_IDLE : c_START;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_pop       = 1'b0;
    w_line_next = 1'b1;
    w_busy      = (r_state != c_IDLE);
    case (r_state)
      c_IDLE: begin
        w_pop       = ~w_empty;
        w_line_next = w_empty;
      end
      c_START: w_line_next = r_shift[0];
      c_DATA:  w_line_next = w_last_bit ? (c_HAS_PAR ? r_par : 1'b1) : r_shift[0];
      c_STOP: begin
        w_pop       = w_last_stop & ~w_empty;
        w_line_next = ~(w_last_stop & ~w_empty);
      end
      default: w_line_next = 1'b1;
    endcase
  end

  always_ff @(posedge BRclk or negedge reset) begin
    if (!reset) begin
      r_line     <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
    end else begin
      r_line <= w_line_next;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= w_head_par;
      end else if (r_state == c_START || r_state == c_DATA) begin
        r_shift <= r_shift >> 1;
      end
      r_bit_cnt  <= (r_state == c_DATA) ? r_bit_cnt + 4'd1 : 4'd0;
      r_stop_cnt <= (r_state == c_STOP) ? r_stop_cnt + 1'b1 : 1'b0;
    end
  end

  assign bus.UART_TX  = r_line;
  assign bus.tx_full  = w_full;
  assign bus.tx_empty = w_empty;
  assign bus.tx_count = r_count;
  assign bus.tx_busy  = w_busy;
  assign bus.tx_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It runs entirely on the baud-rate clock BRclk, and each BRclk cycle is one bit period on the line. The data width, parity mode and stop-bit count are set by parameters. Queued words are sent back to back with no idle gap between frames. The producer is synchronous to BRclk; any crossing from the core clock domain happens upstream of this block.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
FIFO_AW, 2, FIFO address width; depth is 2**FIFO_AW (default 4).

Ports:
BRclk  in  1  baud clock; one bit period per cycle.
reset  in  1  asynchronous reset, active-low.
tx_en  in  1  write strobe; pushes tx_data into the FIFO.
tx_data  in  DATA_W  word to send, LSB transmitted first.
ovf_clr  in  1  clears the tx_ovf flag.
UART_TX  out  1  serial line output, registered, idle high.
tx_full  out  1  FIFO holds 2**FIFO_AW words.
tx_empty  out  1  FIFO holds 0 words.
tx_count  out  FIFO_AW+1  number of words currently in the FIFO.
tx_busy  out  1  a frame is currently on the line.
tx_ovf  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: UART_TX=1, tx_count=0, tx_empty=1, tx_full=0, tx_busy=0, tx_ovf=0.
  - FSM goes to IDLE and the FIFO pointers go to 0.
  - Reset asserted mid-frame aborts the frame immediately; the line returns high and no partial data is resumed after reset.
- FIFO write:
  - A word is accepted at a BRclk edge when tx_en=1 and tx_count<depth before that edge.
  - A pop at the same edge does not make room for a write at that edge.
  - tx_en=1 while full drops the word and sets tx_ovf=1.
  - tx_ovf stays set until a cycle with ovf_clr=1. If ovf_clr and a new overflow occur on the same edge, the overflow wins.
- tx_count: +1 on write only, -1 on pop only, unchanged when both or neither occur. tx_full and tx_empty are decoded from tx_count.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: UART_TX=1. If tx_count>0, pop the head word into the shift register, drive UART_TX<=0 and go to START.
  - START: one cycle, then UART_TX<=bit0 and go to DATA.
  - DATA: DATA_W cycles, bits sent LSB first using a bit counter 0..DATA_W-1. After the last bit, go to PAR if PARITY!=0, otherwise go to STOP with UART_TX<=1.
  - PAR: one cycle. For even parity the bit is the XOR of the data bits; for odd parity it is the inverted XOR. Then go to STOP.
  - STOP: STOP_BITS cycles with UART_TX=1. On the edge ending the last stop bit:
    - if tx_count>0, pop the next word and go to START with UART_TX<=0 (no idle gap);
    - otherwise go to IDLE.
- Latency: a word written at edge N into an empty FIFO while the FSM is IDLE gets its start bit at edge N+1.
- Frame length in cycles: 1 + DATA_W + (PARITY!=0) + STOP_BITS.
- tx_busy=1 in every state except IDLE.
- tx_data is sampled at write time only; changes to tx_data after the write do not affect a queued word.
- Parameter values outside the legal ranges are unsupported; no runtime checking is required.

Test Plan:
- Defaults (8 data bits, no parity, 1 stop): write 0xA5 while idle -> from the next edge UART_TX sequence is 0,1,0,1,0,0,1,0,1,1 (10 cycles), then stays 1; tx_busy high for exactly those 10 cycles.
- PARITY=2, then PARITY=1: write 0xA5 -> parity bit 0 (even) and 1 (odd) after the data bits; PARITY=2 with 0x01 -> parity bit 1.
- Defaults: write 0x00 and then 0xFF on consecutive edges -> two 10-cycle frames back to back, with no high cycle between the stop bit of the first frame and the start bit of the second; tx_count reads 1, then 0.
- Depth 4, idle: tx_en high for 6 consecutive edges -> tx_count 1,1,2,3,4,4; the 6th word is dropped; tx_ovf=1 until ovf_clr is pulsed; the 5 accepted words appear on the line in order.
- STOP_BITS=2, DATA_W=7: write 0x55 -> frame 0,1,0,1,0,1,0,1,1,1 (10 cycles).
- Assert reset during data bit 3 with 2 words queued -> UART_TX=1, tx_count=0 and tx_busy=0 immediately; the line stays high after reset is released.
